// File: rtl/parking_gate_ctrl.sv
// Parking gate front end: syncs and debounces both loop sensors, arbitrates
// enter/exit requests to the occupancy FSM and drives barriers / denied flags.
module parking_gate_ctrl #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int OPEN_CYCLES     = 8
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic sens_in_raw,
  input  logic sens_out_raw,
  input  logic open_door,
  output logic enter,
  output logic exit,
  output logic gate_in_open,
  output logic gate_out_open,
  output logic in_denied,
  output logic out_denied
);

  // state  | meaning
  // IDLE   | no vehicle being handled, waiting for debounced arrival
  // WAIT   | arrival seen, other lane holds the request slot
  // REQ    | request pulse to occupancy FSM, open_door sampled
  // OPEN   | barrier up, hold timer running / vehicle still on loop
  // DENIED | request refused, flag held until loop clears
  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_REQ, S_OPEN, S_DENIED} lane_state_e;

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int TW = (OPEN_CYCLES > 1) ? $clog2(OPEN_CYCLES) : 1;
  localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [TW-1:0] T_LOAD  = TW'(OPEN_CYCLES - 1);

  // lane index 0 = entrance, 1 = exit
  logic [1:0]    raw_s;
  logic [1:0]    sync1_q, sync2_q;
  logic [1:0]    deb_q, deb_d, rise_q, rise_d;
  logic [CW-1:0] cnt_q [2];
  logic [CW-1:0] cnt_d [2];
  lane_state_e   st_q  [2];
  lane_state_e   st_d  [2];
  logic [TW-1:0] tmr_q [2];
  logic [TW-1:0] tmr_d [2];
  logic          last_grant_q, last_grant_d;
  logic [1:0]    want, grant;
  logic [1:0]    req_q, req_d, open_q, open_d, den_q, den_d;

  assign raw_s = {sens_out_raw, sens_in_raw};

  always_comb begin
    deb_d        = deb_q;
    rise_d       = '0;
    want         = '0;
    grant        = '0;
    last_grant_d = last_grant_q;
    req_d        = '0;
    open_d       = '0;
    den_d        = '0;
    for (int i = 0; i < 2; i++) begin
      cnt_d[i] = '0;
      st_d[i]  = st_q[i];
      tmr_d[i] = tmr_q[i];
    end

    // Debounce: flip once the mismatch has persisted DEBOUNCE_CYCLES samples
    for (int i = 0; i < 2; i++) begin
      if (sync2_q[i] != deb_q[i]) begin
        if (cnt_q[i] == DB_LAST) begin
          deb_d[i]  = sync2_q[i];
          rise_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CW'(1);
        end
      end
      want[i] = ((st_q[i] == S_IDLE) && rise_q[i]) ||
                ((st_q[i] == S_WAIT) && deb_q[i]);
    end

    // last_grant_q: 0 = entrance got the slot last, 1 = exit did
    if (want == 2'b11) grant = last_grant_q ? 2'b01 : 2'b10;
    else               grant = want;
    if (grant[0])      last_grant_d = 1'b0;
    else if (grant[1]) last_grant_d = 1'b1;

    for (int i = 0; i < 2; i++) begin
      case (st_q[i])
        S_IDLE:   if (rise_q[i]) st_d[i] = grant[i] ? S_REQ : S_WAIT;
        S_WAIT: begin
          if (grant[i])       st_d[i] = S_REQ;
          else if (!deb_q[i]) st_d[i] = S_IDLE;
        end
        S_REQ: begin
          if (open_door) begin
            st_d[i]  = S_OPEN;
            tmr_d[i] = T_LOAD;
          end else begin
            st_d[i] = S_DENIED;
          end
        end
        S_OPEN: begin
          if (tmr_q[i] != '0)  tmr_d[i] = tmr_q[i] - TW'(1);
          else if (!deb_q[i])  st_d[i]  = S_IDLE;
        end
        S_DENIED: if (!deb_q[i]) st_d[i] = S_IDLE;
        default:  st_d[i] = S_IDLE;
      endcase
      req_d[i]  = (st_d[i] == S_REQ);
      open_d[i] = (st_d[i] == S_OPEN);
      den_d[i]  = (st_d[i] == S_DENIED);
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      sync1_q      <= '0;
      sync2_q      <= '0;
      deb_q        <= '0;
      rise_q       <= '0;
      last_grant_q <= 1'b1;
      req_q        <= '0;
      open_q       <= '0;
      den_q        <= '0;
      for (int i = 0; i < 2; i++) begin
        cnt_q[i] <= '0;
        st_q[i]  <= S_IDLE;
        tmr_q[i] <= '0;
      end
    end else begin
      sync1_q      <= raw_s;
      sync2_q      <= sync1_q;
      deb_q        <= deb_d;
      rise_q       <= rise_d;
      last_grant_q <= last_grant_d;
      req_q        <= req_d;
      open_q       <= open_d;
      den_q        <= den_d;
      for (int i = 0; i < 2; i++) begin
        cnt_q[i] <= cnt_d[i];
        st_q[i]  <= st_d[i];
        tmr_q[i] <= tmr_d[i];
      end
    end
  end

  assign enter         = req_q[0];
  assign exit          = req_q[1];
  assign gate_in_open  = open_q[0];
  assign gate_out_open = open_q[1];
  assign in_denied     = den_q[0];
  assign out_denied    = den_q[1];

endmodule

// File: tb/tb_parking_gate_ctrl.sv
// Scoreboard bench for parking_gate_ctrl: stimulus queues the expected output
// vector changes (edge number + value); a monitor pops them as outputs change.
module tb_parking_gate_ctrl;

  logic CLK = 1'b0;
  logic RST_N;
  logic sens_in_raw, sens_out_raw, open_door;
  logic enter, exit, gate_in_open, gate_out_open, in_denied, out_denied;
  logic od_en;

  parking_gate_ctrl #(.DEBOUNCE_CYCLES(4), .OPEN_CYCLES(8)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .sens_in_raw(sens_in_raw), .sens_out_raw(sens_out_raw),
    .open_door(open_door),
    .enter(enter), .exit(exit),
    .gate_in_open(gate_in_open), .gate_out_open(gate_out_open),
    .in_denied(in_denied), .out_denied(out_denied)
  );

  // occupancy FSM stand-in: grants whatever request is presented when enabled
  assign open_door = od_en & (enter | exit);

  always #5 CLK = ~CLK;

  typedef struct {
    int         e_n;
    logic [5:0] val;
  } exp_t;

  exp_t sb[$];
  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;

  always @(posedge CLK) cyc++;

  task automatic expect_at(input int n, input logic [5:0] v);
    exp_t e;
    e.e_n = n;
    e.val = v;
    sb.push_back(e);
  endtask

  // returns with inputs set just before edge n
  task automatic goto(input int n);
    while (cyc < n - 1) @(negedge CLK);
  endtask

  // output vector order: {enter, exit, gate_in, gate_out, in_denied, out_denied}
  logic [5:0] cur, prev;
  bit         first = 1'b1;

  always @(negedge CLK) begin
    if (cyc >= 1) begin
      cur = {enter, exit, gate_in_open, gate_out_open, in_denied, out_denied};
      total++;
      if (enter === 1'b1 && exit === 1'b1) begin
        bad++;
        $display("FAIL req_exclusive edge=%0d enter=%b exit=%b required not both 1", cyc, enter, exit);
      end
      if (first || cur !== prev) begin
        total++;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL out_change edge=%0d got=%b required no change", cyc, cur);
        end else begin
          exp_t e;
          e = sb.pop_front();
          if (e.e_n != cyc || e.val !== cur) begin
            bad++;
            $display("FAIL out_change got edge=%0d val=%b required edge=%0d val=%b",
                     cyc, cur, e.e_n, e.val);
          end
        end
      end
      prev  = cur;
      first = 1'b0;
    end
  end

  initial begin
    RST_N = 1'b0; sens_in_raw = 1'b0; sens_out_raw = 1'b0; od_en = 1'b1;

    // reset state
    expect_at(1, 6'b000000);
    goto(3); RST_N = 1'b1;

    // 1: single entry, granted, sensor held 20 cycles
    expect_at(16, 6'b100000);
    expect_at(17, 6'b001000);
    expect_at(36, 6'b000000);
    goto(10); sens_in_raw = 1'b1;
    goto(30); sens_in_raw = 1'b0;

    // 2: 3-cycle glitch, no output activity expected
    goto(50); sens_in_raw = 1'b1;
    goto(53); sens_in_raw = 1'b0;

    // 3: reset restores tie-break to entry; two ties, entry wins both
    goto(60); RST_N = 1'b0;
    goto(61); RST_N = 1'b1;
    expect_at(76, 6'b100000);
    expect_at(77, 6'b011000);
    expect_at(78, 6'b001100);
    expect_at(96, 6'b000000);
    goto(70); sens_in_raw = 1'b1; sens_out_raw = 1'b1;
    goto(90); sens_in_raw = 1'b0; sens_out_raw = 1'b0;
    expect_at(116, 6'b100000);
    expect_at(117, 6'b011000);
    expect_at(118, 6'b001100);
    expect_at(136, 6'b000000);
    goto(110); sens_in_raw = 1'b1; sens_out_raw = 1'b1;
    goto(130); sens_in_raw = 1'b0; sens_out_raw = 1'b0;

    // 4: entry denied, then a fresh granted entry
    expect_at(156, 6'b100000);
    expect_at(157, 6'b000010);
    expect_at(176, 6'b000000);
    goto(150); od_en = 1'b0; sens_in_raw = 1'b1;
    goto(170); sens_in_raw = 1'b0;
    expect_at(196, 6'b100000);
    expect_at(197, 6'b001000);
    expect_at(216, 6'b000000);
    goto(190); od_en = 1'b1; sens_in_raw = 1'b1;
    goto(210); sens_in_raw = 1'b0;

    // 4b: tie after an entry grant goes to exit
    expect_at(236, 6'b010000);
    expect_at(237, 6'b100100);
    expect_at(238, 6'b001100);
    expect_at(256, 6'b000000);
    goto(230); sens_in_raw = 1'b1; sens_out_raw = 1'b1;
    goto(250); sens_in_raw = 1'b0; sens_out_raw = 1'b0;

    // 4c: exit denied (lot empty)
    expect_at(276, 6'b010000);
    expect_at(277, 6'b000001);
    expect_at(296, 6'b000000);
    goto(270); od_en = 1'b0; sens_out_raw = 1'b1;
    goto(290); sens_out_raw = 1'b0;

    // 5: vehicle lingers on exit loop 30 cycles after grant
    expect_at(316, 6'b010000);
    expect_at(317, 6'b000100);
    expect_at(353, 6'b000000);
    goto(310); od_en = 1'b1; sens_out_raw = 1'b1;
    goto(347); sens_out_raw = 1'b0;

    // 6: reset while entrance gate open, sensor still held
    expect_at(376, 6'b100000);
    expect_at(377, 6'b001000);
    expect_at(385, 6'b000000);
    expect_at(392, 6'b100000);
    expect_at(393, 6'b001000);
    expect_at(416, 6'b000000);
    goto(370); sens_in_raw = 1'b1;
    goto(385); RST_N = 1'b0;
    goto(386); RST_N = 1'b1;
    goto(410); sens_in_raw = 1'b0;

    goto(430);
    @(negedge CLK);
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL sb_drained remaining=%0d required 0 next_edge=%0d",
               sb.size(), sb[0].e_n);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
